// File: rtl/writer_pkg.sv
// Shared types for the accumulating writer and its result reader.
// Result payload is stored bit-exact; no arithmetic is applied downstream.
package writer_pkg;

   localparam int unsigned DWIDTH = 8;
   localparam int unsigned VWIDTH = 4;

   typedef struct packed {
      logic [VWIDTH-1:0] cnt;
      logic [DWIDTH:0]   sum;
   } result_t;

   typedef enum logic {
      S_EMPTY,
      S_VALID
   } rd_state_e;

endpackage

// File: rtl/wr_result_fifo.sv
// In-order result storage behind the reader's output register.
// Flushes pointers and occupancy on clear; contents are left stale.
module wr_result_fifo
   import writer_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic    clk,
   input  logic    rst,
   input  logic    clear,
   input  logic    wr_en,
   input  logic    rd_en,
   input  result_t wr_result,
   output result_t rd_result,
   output logic    empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   result_t         mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [CW-1:0]   count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
         case ({wr_en, rd_en})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en && !clear) mem[wr_ptr] <= wr_result;
   end

   assign rd_result = mem[rd_ptr];
   assign empty     = (count == '0);

endmodule

// File: rtl/wr_result_reader.sv
// Captures writer results into an in-order queue and presents them on a
// valid/ready port through a registered head stage.
module wr_result_reader
   import writer_pkg::*;
#(
   parameter int unsigned DWIDTH = writer_pkg::DWIDTH,
   parameter int unsigned VWIDTH = writer_pkg::VWIDTH,
   parameter int unsigned DEPTH  = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clear,
   input  logic                       wr_valid,
   input  logic [DWIDTH:0]            wr_data,
   input  logic [VWIDTH-1:0]          wr_cnt,
   output logic                       rd_valid,
   input  logic                       rd_ready,
   output logic [DWIDTH:0]            rd_data,
   output logic [VWIDTH-1:0]          rd_cnt,
   output logic [$clog2(DEPTH+1)-1:0] level,
   output logic                       full,
   output logic                       overflow
);

   localparam int unsigned LW = $clog2(DEPTH + 1);

   rd_state_e state;
   logic      push;
   logic      pop;
   logic      fifo_rd;
   logic      fifo_empty;
   result_t   fifo_head;
   result_t   wr_result;

   assign wr_result = '{cnt: wr_cnt, sum: wr_data};
   assign full      = (level == LW'(DEPTH));
   assign pop       = rd_valid && rd_ready;
   assign push      = wr_valid && (!full || pop) && !clear;
   // Head register refills from the queue when idle or when its result is taken.
   assign fifo_rd   = !fifo_empty && !clear && ((state == S_EMPTY) || pop);

   wr_result_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .clear     (clear),
      .wr_en     (push),
      .rd_en     (fifo_rd),
      .wr_result (wr_result),
      .rd_result (fifo_head),
      .empty     (fifo_empty)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_EMPTY;
         rd_valid <= 1'b0;
         rd_data  <= '0;
         rd_cnt   <= '0;
         level    <= '0;
         overflow <= 1'b0;
      end else if (clear) begin
         state    <= S_EMPTY;
         rd_valid <= 1'b0;
         level    <= '0;
         overflow <= 1'b0;
      end else begin
         if (wr_valid && full && !pop) overflow <= 1'b1;
         if (push && !pop)      level <= level + 1'b1;
         else if (pop && !push) level <= level - 1'b1;
         case (state)
            S_EMPTY: begin
               if (!fifo_empty) begin
                  rd_data  <= fifo_head.sum;
                  rd_cnt   <= fifo_head.cnt;
                  rd_valid <= 1'b1;
                  state    <= S_VALID;
               end
            end
            S_VALID: begin
               if (pop) begin
                  if (!fifo_empty) begin
                     rd_data <= fifo_head.sum;
                     rd_cnt  <= fifo_head.cnt;
                  end else begin
                     rd_valid <= 1'b0;
                     state    <= S_EMPTY;
                  end
               end
            end
            default: begin
               rd_valid <= 1'b0;
               state    <= S_EMPTY;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wr_result_reader.sv
// Scoreboard bench for wr_result_reader: cycle model of the queue and head
// stage, plus directed scenarios with fixed expected values.
module tb_wr_result_reader;

   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       clear = 1'b0;
   logic       wr_valid = 1'b0;
   logic [8:0] wr_data = '0;
   logic [3:0] wr_cnt = '0;
   logic       rd_ready = 1'b0;
   logic       rd_valid;
   logic [8:0] rd_data;
   logic [3:0] rd_cnt;
   logic [2:0] level;
   logic       full;
   logic       overflow;

   wr_result_reader #(
      .DWIDTH (8),
      .VWIDTH (4),
      .DEPTH  (DEPTH)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .clear    (clear),
      .wr_valid (wr_valid),
      .wr_data  (wr_data),
      .wr_cnt   (wr_cnt),
      .rd_valid (rd_valid),
      .rd_ready (rd_ready),
      .rd_data  (rd_data),
      .rd_cnt   (rd_cnt),
      .level    (level),
      .full     (full),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Model: m_q holds every held result, head first; m_valid mirrors rd_valid.
   logic [12:0] m_q[$];
   bit          m_valid = 1'b0;
   bit          m_ovf = 1'b0;
   logic [12:0] got_q[$];
   int          got_cyc[$];

   always @(posedge clk or posedge rst) begin
      bit m_pop, m_push, m_full;
      int fcnt;
      if (rst) begin
         m_q.delete();
         m_valid = 1'b0;
         m_ovf   = 1'b0;
      end else begin
         cyc++;
         m_pop  = m_valid && rd_ready;
         m_full = (m_q.size() == DEPTH);
         m_push = wr_valid && (!m_full || m_pop);
         if (clear) begin
            m_q.delete();
            m_valid = 1'b0;
            m_ovf   = 1'b0;
         end else begin
            fcnt = m_q.size() - (m_valid ? 1 : 0);
            if (wr_valid && m_full && !m_pop) m_ovf = 1'b1;
            if (m_pop) void'(m_q.pop_front());
            if (m_valid) m_valid = m_pop ? (fcnt > 0) : 1'b1;
            else         m_valid = (fcnt > 0);
            if (m_push) m_q.push_back({wr_cnt, wr_data});
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         check("rd_valid", rd_valid, m_valid);
         check("level", level, m_q.size());
         check("full", full, m_q.size() == DEPTH);
         check("overflow", overflow, m_ovf);
         if (m_valid && m_q.size() > 0) begin
            check("rd_data", rd_data, m_q[0][8:0]);
            check("rd_cnt", rd_cnt, m_q[0][12:9]);
         end
         if (rd_valid && rd_ready) begin
            got_q.push_back({rd_cnt, rd_data});
            got_cyc.push_back(cyc);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [12:0] r);
      wr_valid = 1'b1;
      {wr_cnt, wr_data} = r;
      step();
      wr_valid = 1'b0;
   endtask

   task automatic check_drain(input string tag, input logic [8:0] e0, input logic [8:0] e1,
                              input logic [8:0] e2, input logic [8:0] e3, input int n);
      logic [8:0] exp [4];
      exp = '{e0, e1, e2, e3};
      check({tag, "_count"}, got_q.size(), n);
      if (got_q.size() == n) begin
         for (int i = 0; i < n; i++) check(tag, got_q[i][8:0], exp[i]);
         check({tag, "_gapless"}, got_cyc[n-1] - got_cyc[0], n - 1);
      end
   endtask

   initial begin
      step();
      check("reset_valid", rd_valid, 0);
      check("reset_level", level, 0);
      check("reset_data", {rd_cnt, rd_data}, 0);
      step();
      rst = 1'b0;
      step();

      // Single result latency and hand-off
      rd_ready = 1'b1;
      push({4'd3, 9'h1FE});
      check("t2_not_yet", rd_valid, 0);
      step();
      check("t2_valid", rd_valid, 1);
      check("t2_data", rd_data, 9'h1FE);
      check("t2_cnt", rd_cnt, 3);
      step();
      check("t2_empty", rd_valid, 0);
      check("t2_level", level, 0);

      // Overfill then drain
      rd_ready = 1'b0;
      for (int i = 1; i <= 5; i++) push({4'(i), 9'(i)});
      check("t3_level", level, 4);
      check("t3_full", full, 1);
      check("t3_ovf", overflow, 1);
      got_q.delete(); got_cyc.delete();
      rd_ready = 1'b1;
      repeat (5) step();
      check_drain("t3_drain", 9'd1, 9'd2, 9'd3, 9'd4, 4);

      // Push and pop together while full
      clear = 1'b1; step(); clear = 1'b0;
      check("t4_cleared_ovf", overflow, 0);
      rd_ready = 1'b0;
      for (int i = 1; i <= 4; i++) push({4'(i), 9'(i)});
      check("t4_full", full, 1);
      rd_ready = 1'b1;
      push({4'd9, 9'd9});
      check("t4_level", level, 4);
      check("t4_ovf", overflow, 0);
      got_q.delete(); got_cyc.delete();
      repeat (5) step();
      check_drain("t4_drain", 9'd2, 9'd3, 9'd4, 9'd9, 4);

      // Stall holds the head stable
      rd_ready = 1'b0;
      push({4'd5, 9'h0AA});
      step();
      for (int i = 0; i < 3; i++) begin
         step();
         check("t5_valid", rd_valid, 1);
         check("t5_data", rd_data, 9'h0AA);
         check("t5_cnt", rd_cnt, 5);
      end
      rd_ready = 1'b1;
      step();

      // Clear beats a same-cycle push
      rd_ready = 1'b0;
      for (int i = 1; i <= 3; i++) push({4'(i), 9'(i + 16)});
      step();
      check("t6_level", level, 3);
      clear = 1'b1;
      push({4'd7, 9'h055});
      clear = 1'b0;
      check("t6_level0", level, 0);
      check("t6_valid", rd_valid, 0);
      check("t6_ovf", overflow, 0);
      got_q.delete(); got_cyc.delete();
      rd_ready = 1'b1;
      push({4'd1, 9'h011});
      push({4'd2, 9'h022});
      repeat (3) step();
      check_drain("t6_after", 9'h011, 9'h022, 9'h0, 9'h0, 2);

      // Asynchronous reset between edges
      rd_ready = 1'b0;
      for (int i = 1; i <= 3; i++) push({4'(i), 9'(i)});
      step();
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("t1_valid", rd_valid, 0);
      check("t1_level", level, 0);
      check("t1_ovf", overflow, 0);
      step();
      rst = 1'b0;
      step();

      // Random traffic against the model
      repeat (400) begin
         wr_valid = 1'($urandom_range(0, 1));
         wr_data  = 9'($urandom);
         wr_cnt   = 4'($urandom);
         rd_ready = ($urandom_range(0, 3) != 0);
         clear    = ($urandom_range(0, 40) == 0);
         step();
      end
      wr_valid = 1'b0;
      clear = 1'b0;
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
